// File: rtl/fabric_map_tag_cfg_ctrl.sv
// fabric_map_tag_cfg_ctrl: loads a shadow tag table and commits it to cfg_data only at a burst boundary.
// Define FABRIC_MAP_TAG_CFG_DUP_CHECK_EN to include the duplicate source-tag CHECK state.
module fabric_map_tag_cfg_ctrl #(
    parameter int IN_TAG_WIDTH  = 4,
    parameter int OUT_TAG_WIDTH = 2,
    parameter int TABLE_SIZE    = 4,
    localparam int ENTRY_WIDTH  = 1 + IN_TAG_WIDTH + OUT_TAG_WIDTH,
    localparam int IDX_W        = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1,
    localparam int CONFIG_WIDTH = TABLE_SIZE * ENTRY_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [IDX_W-1:0]        wr_index,
    input  logic [ENTRY_WIDTH-1:0]  wr_entry,
    input  logic                    wr_last,
    input  logic                    dp_fire,
    input  logic                    dp_last,
    output logic                    dp_hold,
    output logic [CONFIG_WIDTH-1:0] cfg_data,
    output logic                    cfg_done,
    output logic                    error_valid,
    output logic [15:0]             error_code
);

    localparam logic [15:0] CFG_MAP_TAG_CFG_IDX_RANGE = 16'h0302;
    localparam logic [IDX_W:0] SLOT_COUNT = (IDX_W + 1)'(TABLE_SIZE);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        CHECK    = 3'd2,
        WAIT_BND = 3'd3,
        COMMIT   = 3'd4
    } state_t;

`ifdef FABRIC_MAP_TAG_CFG_DUP_CHECK_EN
    localparam logic [15:0] CFG_MAP_TAG_DUP_TAG = 16'h0301;
    localparam state_t AFTER_LOAD = CHECK;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_SIZE - 1);
`else
    localparam state_t AFTER_LOAD = WAIT_BND;
`endif

    state_t                  state;
    logic                    dp_busy;
    logic [CONFIG_WIDTH-1:0] shadow;
    logic                    wr_fire;
    logic                    idx_bad;
    logic                    err_hit;
    logic [15:0]             err_code_nxt;

    function automatic logic [CONFIG_WIDTH-1:0] put_entry(
        input logic [CONFIG_WIDTH-1:0] tbl,
        input logic [IDX_W-1:0]        idx,
        input logic [ENTRY_WIDTH-1:0]  entry
    );
        logic [CONFIG_WIDTH-1:0] res;
        res = tbl;
        res[int'(idx) * ENTRY_WIDTH +: ENTRY_WIDTH] = entry;
        return res;
    endfunction

    assign wr_ready = (state == IDLE) || (state == LOAD);
    assign wr_fire  = wr_valid && wr_ready;
    // Only reachable when TABLE_SIZE is not a power of two.
    assign idx_bad  = ({1'b0, wr_index} >= SLOT_COUNT);

`ifdef FABRIC_MAP_TAG_CFG_DUP_CHECK_EN
    logic [IDX_W-1:0]       chk_idx;
    logic [ENTRY_WIDTH-1:0] cur_entry;
    logic                   dup_hit;

    assign cur_entry = shadow[int'(chk_idx) * ENTRY_WIDTH +: ENTRY_WIDTH];

    // Compare the entry under test against every later valid entry.
    always_comb begin
        dup_hit = 1'b0;
        if ((state == CHECK) && cur_entry[0]) begin
            for (int j = 0; j < TABLE_SIZE; j++) begin
                if ((j > int'(chk_idx)) && shadow[j * ENTRY_WIDTH] &&
                    (shadow[j * ENTRY_WIDTH + 1 +: IN_TAG_WIDTH] == cur_entry[IN_TAG_WIDTH:1])) begin
                    dup_hit = 1'b1;
                end else begin
                    dup_hit = dup_hit;
                end
            end
        end else begin
            dup_hit = 1'b0;
        end
    end
`endif

    // Error source selection for the first-error latch.
    always_comb begin
        err_hit      = 1'b0;
        err_code_nxt = 16'h0000;
        if (wr_fire && idx_bad) begin
            err_hit      = 1'b1;
            err_code_nxt = CFG_MAP_TAG_CFG_IDX_RANGE;
        end
`ifdef FABRIC_MAP_TAG_CFG_DUP_CHECK_EN
        else if (dup_hit) begin
            err_hit      = 1'b1;
            err_code_nxt = CFG_MAP_TAG_DUP_TAG;
        end
`endif
        else begin
            err_hit = 1'b0;
        end
    end

    // Upstream gate: closed at a burst boundary while waiting, and during the commit cycle.
    always_comb begin
        case (state)
            WAIT_BND: dp_hold = !dp_busy;
            COMMIT:   dp_hold = 1'b1;
            default:  dp_hold = 1'b0;
        endcase
    end

    // Sequencer, burst tracker, shadow/live tables and error latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dp_busy     <= 1'b0;
            shadow      <= '0;
            cfg_data    <= '0;
            cfg_done    <= 1'b0;
            error_valid <= 1'b0;
            error_code  <= 16'h0000;
`ifdef FABRIC_MAP_TAG_CFG_DUP_CHECK_EN
            chk_idx     <= '0;
`endif
        end else begin
            cfg_done <= 1'b0;
            if (dp_fire) begin
                dp_busy <= !dp_last;
            end
            if (err_hit && !error_valid) begin
                error_valid <= 1'b1;
                error_code  <= err_code_nxt;
            end
`ifdef FABRIC_MAP_TAG_CFG_DUP_CHECK_EN
            if (state != CHECK) begin
                chk_idx <= '0;
            end
`endif
            case (state)
                IDLE: begin
                    if (wr_fire) begin
                        // Untouched slots inherit the live table so partial loads are legal.
                        shadow <= idx_bad ? cfg_data : put_entry(cfg_data, wr_index, wr_entry);
                        state  <= wr_last ? AFTER_LOAD : LOAD;
                    end
                end
                LOAD: begin
                    if (wr_fire) begin
                        if (!idx_bad) begin
                            shadow <= put_entry(shadow, wr_index, wr_entry);
                        end
                        if (wr_last) begin
                            state <= AFTER_LOAD;
                        end
                    end
                end
`ifdef FABRIC_MAP_TAG_CFG_DUP_CHECK_EN
                CHECK: begin
                    if (dup_hit) begin
                        state <= IDLE;
                    end else if (chk_idx == LAST_IDX) begin
                        state <= WAIT_BND;
                    end else begin
                        chk_idx <= chk_idx + 1'b1;
                    end
                end
`endif
                WAIT_BND: begin
                    if (!dp_busy) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    cfg_data <= shadow;
                    cfg_done <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fabric_map_tag_cfg_ctrl.sv
// Self-checking bench for fabric_map_tag_cfg_ctrl: a table-level model predicts commits, latency and errors.
module tb_fabric_map_tag_cfg_ctrl;

    localparam int TS  = 4;
    localparam int EW  = 7;
    localparam int WIN = 12;
`ifdef FABRIC_MAP_TAG_CFG_DUP_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif
    localparam int LAT  = CHECK_EN ? TS + 2 : 2;
    localparam int LAT3 = CHECK_EN ? 3 + 2 : 2;
    localparam logic [15:0] CODE_DUP   = 16'h0301;
    localparam logic [15:0] CODE_RANGE = 16'h0302;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             wr_valid, wr_ready, wr_last, dp_fire, dp_last, dp_hold, cfg_done, error_valid;
    logic [1:0]       wr_index;
    logic [EW-1:0]    wr_entry;
    logic [TS*EW-1:0] cfg_data;
    logic [15:0]      error_code;

    logic             t3_valid, t3_ready, t3_last, t3_fire, t3_dlast, t3_hold, t3_done, t3_ev;
    logic [1:0]       t3_index;
    logic [EW-1:0]    t3_entry;
    logic [3*EW-1:0]  t3_cfg;
    logic [15:0]      t3_ec;

    fabric_map_tag_cfg_ctrl #(.IN_TAG_WIDTH(4), .OUT_TAG_WIDTH(2), .TABLE_SIZE(TS)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_index(wr_index),
        .wr_entry(wr_entry), .wr_last(wr_last), .dp_fire(dp_fire), .dp_last(dp_last),
        .dp_hold(dp_hold), .cfg_data(cfg_data), .cfg_done(cfg_done),
        .error_valid(error_valid), .error_code(error_code)
    );

    fabric_map_tag_cfg_ctrl #(.IN_TAG_WIDTH(4), .OUT_TAG_WIDTH(2), .TABLE_SIZE(3)) dut3 (
        .clk(clk), .rst(rst), .wr_valid(t3_valid), .wr_ready(t3_ready), .wr_index(t3_index),
        .wr_entry(t3_entry), .wr_last(t3_last), .dp_fire(t3_fire), .dp_last(t3_dlast),
        .dp_hold(t3_hold), .cfg_data(t3_cfg), .cfg_done(t3_done),
        .error_valid(t3_ev), .error_code(t3_ec)
    );

    // Reference model: live table, pending load and first-error latch.
    logic [EW-1:0] m_live   [TS];
    logic [EW-1:0] m_shadow [TS];
    bit            m_ev;
    logic [15:0]   m_ec;
    int            ld_n;
    logic [1:0]    ld_idx [8];
    logic [EW-1:0] ld_ent [8];

    function automatic logic [TS*EW-1:0] exp_cfg();
        logic [TS*EW-1:0] v;
        v = '0;
        for (int i = 0; i < TS; i++) v[i*EW +: EW] = m_live[i];
        return v;
    endfunction

    function automatic bit has_dup();
        for (int i = 0; i < TS; i++)
            for (int j = i + 1; j < TS; j++)
                if (m_shadow[i][0] && m_shadow[j][0] && (m_shadow[i][4:1] == m_shadow[j][4:1])) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [EW-1:0] mk(input int dst, input int src, input int v);
        return {2'(dst), 4'(src), 1'(v)};
    endfunction

    task automatic model_apply(output bit commit);
        for (int i = 0; i < TS; i++) m_shadow[i] = m_live[i];
        for (int b = 0; b < ld_n; b++) m_shadow[ld_idx[b]] = ld_ent[b];
        if (CHECK_EN && has_dup()) begin
            commit = 1'b0;
            if (!m_ev) begin
                m_ev = 1'b1;
                m_ec = CODE_DUP;
            end
        end else begin
            commit = 1'b1;
            for (int i = 0; i < TS; i++) m_live[i] = m_shadow[i];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < TS; i++) m_live[i] = '0;
        m_ev = 1'b0;
        m_ec = 16'h0000;
    endtask

    task automatic drive_load(input bit gaps);
        for (int b = 0; b < ld_n; b++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                @(negedge clk);
                wr_valid = 1'b0;
            end
            @(negedge clk);
            wr_valid = 1'b1;
            wr_index = ld_idx[b];
            wr_entry = ld_ent[b];
            wr_last  = (b == ld_n - 1);
            checks++;
            if (wr_ready !== 1'b1) begin
                failures++;
                $display("FAIL wr_ready_beat: got %b expected 1", wr_ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    // Called at the negedge right after the triggering edge (m=0).
    task automatic wait_outcome(input string name, input bit commit, input int lat);
        int first, cnt, exp_first;
        first = -1;
        cnt   = 0;
        for (int m = 0; m < WIN; m++) begin
            if (m > 0) @(negedge clk);
            if (cfg_done === 1'b1) begin
                if (first < 0) first = m;
                cnt++;
            end
        end
        exp_first = commit ? lat : -1;
        checks++;
        if (first != exp_first) begin
            failures++;
            $display("FAIL %s_done_cycle: got %0d expected %0d", name, first, exp_first);
        end
        checks++;
        if (cnt != (commit ? 1 : 0)) begin
            failures++;
            $display("FAIL %s_done_count: got %0d expected %0d", name, cnt, commit ? 1 : 0);
        end
        checks++;
        if (cfg_data !== exp_cfg()) begin
            failures++;
            $display("FAIL %s_cfg_data: got %h expected %h", name, cfg_data, exp_cfg());
        end
        checks++;
        if (error_valid !== m_ev || error_code !== m_ec) begin
            failures++;
            $display("FAIL %s_error: got %b/%h expected %b/%h", name, error_valid, error_code, m_ev, m_ec);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_back_idle: got %b expected 1", name, wr_ready);
        end
    endtask

    task automatic test_reset();
        int seen;
        checks++;
        if (cfg_data !== '0 || wr_ready !== 1'b1 || dp_hold !== 1'b0 || cfg_done !== 1'b0 ||
            error_valid !== 1'b0 || error_code !== 16'h0000) begin
            failures++;
            $display("FAIL reset_values: got cfg=%h rdy=%b hold=%b done=%b ev=%b ec=%h expected 0/1/0/0/0/0",
                     cfg_data, wr_ready, dp_hold, cfg_done, error_valid, error_code);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cfg_done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_idle_done: got %0d expected 0", seen);
        end
    endtask

    task automatic test_two_entry();
        bit commit;
        ld_n = 2;
        ld_idx[0] = 2'd0; ld_ent[0] = mk(1, 3, 1);
        ld_idx[1] = 2'd2; ld_ent[1] = mk(2, 5, 1);
        model_apply(commit);
        drive_load(1'b0);
        wait_outcome("two_entry", commit, LAT);
    endtask

    task automatic test_duplicate();
        bit commit;
        ld_n = 2;
        ld_idx[0] = 2'd0; ld_ent[0] = mk(0, 7, 1);
        ld_idx[1] = 2'd1; ld_ent[1] = mk(3, 7, 1);
        model_apply(commit);
        drive_load(1'b0);
        wait_outcome("duplicate", commit, LAT);
    endtask

    task automatic test_random_loads();
        bit commit;
        for (int it = 0; it < 25; it++) begin
            ld_n = $urandom_range(1, 4);
            for (int b = 0; b < ld_n; b++) begin
                ld_idx[b] = 2'($urandom_range(0, 3));
                ld_ent[b] = mk($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 1));
            end
            model_apply(commit);
            drive_load(1'b1);
            wait_outcome("random_load", commit, LAT);
        end
    endtask

    task automatic full_distinct_load();
        ld_n = TS;
        for (int b = 0; b < TS; b++) begin
            ld_idx[b] = 2'(b);
            ld_ent[b] = mk(b, 8 + b + $urandom_range(0, 1) * 4, 1);
        end
    endtask

    task automatic test_burst_boundary();
        bit commit;
        int done_cnt, hold_cnt;
        @(negedge clk);
        dp_fire = 1'b1; dp_last = 1'b0;
        @(negedge clk);
        dp_fire = 1'b0;
        full_distinct_load();
        model_apply(commit);
        drive_load(1'b0);
        done_cnt = 0;
        hold_cnt = 0;
        for (int m = 0; m < LAT + 3; m++) begin
            if (m > 0) @(negedge clk);
            if (cfg_done === 1'b1) done_cnt++;
            if (dp_hold !== 1'b0) hold_cnt++;
        end
        checks++;
        if (done_cnt != 0) begin
            failures++;
            $display("FAIL burst_early_commit: got %0d expected 0", done_cnt);
        end
        checks++;
        if (hold_cnt != 0) begin
            failures++;
            $display("FAIL burst_hold_open: got %0d expected 0", hold_cnt);
        end
        @(negedge clk);
        dp_fire = 1'b1; dp_last = 1'b1;
        @(negedge clk);
        dp_fire = 1'b0; dp_last = 1'b0;
        checks++;
        if (dp_hold !== 1'b1) begin
            failures++;
            $display("FAIL burst_hold_boundary: got %b expected 1", dp_hold);
        end
        wait_outcome("burst_commit", commit, 2);
    endtask

    task automatic t3_beat(input logic [1:0] idx, input logic [EW-1:0] ent, input bit last);
        @(negedge clk);
        t3_valid = 1'b1; t3_index = idx; t3_entry = ent; t3_last = last;
        checks++;
        if (t3_ready !== 1'b1) begin
            failures++;
            $display("FAIL range_ready: got %b expected 1", t3_ready);
        end
        @(posedge clk);
    endtask

    task automatic t3_outcome(input string name, input int exp_first, input logic [3*EW-1:0] exp_tbl);
        int first;
        @(negedge clk);
        t3_valid = 1'b0; t3_last = 1'b0;
        first = -1;
        for (int m = 0; m < WIN; m++) begin
            if (m > 0) @(negedge clk);
            if (t3_done === 1'b1 && first < 0) first = m;
        end
        checks++;
        if (first != exp_first) begin
            failures++;
            $display("FAIL %s_done_cycle: got %0d expected %0d", name, first, exp_first);
        end
        checks++;
        if (t3_cfg !== exp_tbl) begin
            failures++;
            $display("FAIL %s_cfg_data: got %h expected %h", name, t3_cfg, exp_tbl);
        end
        checks++;
        if (t3_ev !== 1'b1 || t3_ec !== CODE_RANGE) begin
            failures++;
            $display("FAIL %s_error: got %b/%h expected 1/%h", name, t3_ev, t3_ec, CODE_RANGE);
        end
    endtask

    task automatic test_index_range();
        logic [EW-1:0]   e0, e1, e2;
        logic [3*EW-1:0] tbl;
        e0 = mk(2, 6, 1);
        t3_beat(2'd3, mk(3, 15, 1), 1'b0);
        t3_beat(2'd0, e0, 1'b1);
        tbl = {7'd0, 7'd0, e0};
        t3_outcome("range_drop", LAT3, tbl);
        e1 = mk(1, 7, 1);
        e2 = mk(0, 7, 1);
        t3_beat(2'd1, e1, 1'b0);
        t3_beat(2'd2, e2, 1'b1);
        if (!CHECK_EN) tbl = {e2, e1, e0};
        t3_outcome("range_then_dup", CHECK_EN ? -1 : LAT3, tbl);
    endtask

    task automatic test_reset_mid_wait();
        bit commit;
        int seen;
        @(negedge clk);
        dp_fire = 1'b1; dp_last = 1'b0;
        @(negedge clk);
        dp_fire = 1'b0;
        full_distinct_load();
        model_apply(commit);
        drive_load(1'b0);
        repeat (LAT) @(negedge clk);
        checks++;
        if (wr_ready !== 1'b0 || dp_hold !== 1'b0 || cfg_done !== 1'b0) begin
            failures++;
            $display("FAIL midwait_state: got rdy=%b hold=%b done=%b expected 0/0/0", wr_ready, dp_hold, cfg_done);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++;
        if (cfg_data !== '0 || wr_ready !== 1'b1 || dp_hold !== 1'b0 || cfg_done !== 1'b0 ||
            error_valid !== 1'b0 || error_code !== 16'h0000) begin
            failures++;
            $display("FAIL midwait_reset_values: got cfg=%h rdy=%b hold=%b done=%b ev=%b ec=%h expected 0/1/0/0/0/0",
                     cfg_data, wr_ready, dp_hold, cfg_done, error_valid, error_code);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cfg_done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midwait_no_done: got %0d expected 0", seen);
        end
        ld_n = 1;
        ld_idx[0] = 2'd3; ld_ent[0] = mk(3, 2, 1);
        model_apply(commit);
        drive_load(1'b0);
        wait_outcome("after_reset_load", commit, LAT);
    endtask

    initial begin
        rst = 1'b1;
        wr_valid = 1'b0; wr_index = 2'd0; wr_entry = '0; wr_last = 1'b0;
        dp_fire = 1'b0; dp_last = 1'b0;
        t3_valid = 1'b0; t3_index = 2'd0; t3_entry = '0; t3_last = 1'b0;
        t3_fire = 1'b0; t3_dlast = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_two_entry();
        test_duplicate();
        test_random_loads();
        test_burst_boundary();
        test_index_range();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
